regfile_2r1w_clr: RTL and testbench

//  Parametrised register file for the CPU datapath: two async read ports, one

---
 rtl/regfile_2r1w_clr_if.sv | 25 ++
 rtl/regfile_2r1w_clr.sv | 87 ++++++++
 tb/tb_regfile_2r1w_clr.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_2r1w_clr_if.sv
// rtl/regfile_2r1w_clr_if.sv - write/read/clear port bundle for the 2R1W register file
interface regfile_2r1w_clr_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) ();
    logic             We;
    logic [AW-1:0]    Wn;
    logic [WIDTH-1:0] D;
    logic [AW-1:0]    Rna;
    logic [AW-1:0]    Rnb;
    logic [WIDTH-1:0] Qa;
    logic [WIDTH-1:0] Qb;
    logic             Clr;
    logic             Busy;

    modport master (
        output We, Wn, D, Rna, Rnb, Clr,
        input  Qa, Qb, Busy
    );

    modport slave (
        input  We, Wn, D, Rna, Rnb, Clr,
        output Qa, Qb, Busy
    );
endinterface

// File: rtl/regfile_2r1w_clr.sv
// rtl/regfile_2r1w_clr.sv - 2R1W register file with bypass, optional zero r0 and soft-clear sweep
module regfile_2r1w_clr #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int ZERO_R0 = 1
) (
    input  logic               Clk,
    input  logic               Rst,
    regfile_2r1w_clr_if.slave  bus
);
    typedef enum logic {IDLE, SWEEP} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] reg_q [DEPTH];

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             wn_is_r0;
    logic             bypass_ok;

    assign wn_is_r0 = (ZERO_R0 != 0) && (bus.Wn == '0);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_addr = bus.Wn;
        wr_data = bus.D;
        case (state_q)
            IDLE: begin
                // A clear request in the same cycle as a write wins; the write is dropped.
                if (bus.Clr) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end else if (bus.We && !wn_is_r0) begin
                    wr_en = 1'b1;
                end
            end
            SWEEP: begin
                wr_en   = 1'b1;
                wr_addr = ptr_q;
                wr_data = '0;
                ptr_d   = ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (wr_en) begin
                reg_q[wr_addr] <= wr_data;
            end
        end
    end

    assign bus.Busy  = (state_q == SWEEP);
    assign bypass_ok = bus.We && (state_q == IDLE) && !bus.Clr && !wn_is_r0;

    assign bus.Qa = ((ZERO_R0 != 0) && (bus.Rna == '0)) ? '0
                  : (bypass_ok && (bus.Wn == bus.Rna))   ? bus.D
                  : reg_q[bus.Rna];

    assign bus.Qb = ((ZERO_R0 != 0) && (bus.Rnb == '0)) ? '0
                  : (bypass_ok && (bus.Wn == bus.Rnb))   ? bus.D
                  : reg_q[bus.Rnb];
endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// tb/tb_regfile_2r1w_clr.sv - self-checking bench for regfile_2r1w_clr
module tb_regfile_2r1w_clr;
    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    regfile_2r1w_clr_if #(.WIDTH(32), .AW(5)) bus ();

    regfile_2r1w_clr #(
        .WIDTH(32), .DEPTH(32), .AW(5), .ZERO_R0(1)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: contents frozen at the start of a sweep, plus how many
    // registers the sweep has zeroed so far.
    logic [31:0] m_mem [32];
    logic        m_sweep   = 1'b0;
    int          m_elapsed = 0;
    logic        m_valid   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] rn);
        if (rn == 5'd0) return 32'h0;
        if (bus.We && !m_sweep && !bus.Clr && bus.Wn == rn) return bus.D;
        if (m_sweep && int'(rn) < m_elapsed) return 32'h0;
        return m_mem[rn];
    endfunction

    always @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < 32; i++) m_mem[i] <= 32'h0;
            m_sweep   <= 1'b0;
            m_elapsed <= 0;
            m_valid   <= 1'b1;
        end else if (m_sweep) begin
            if (m_elapsed == 31) begin
                for (int i = 0; i < 32; i++) m_mem[i] <= 32'h0;
                m_sweep   <= 1'b0;
                m_elapsed <= 0;
            end else begin
                m_elapsed <= m_elapsed + 1;
            end
        end else if (bus.Clr) begin
            m_sweep   <= 1'b1;
            m_elapsed <= 0;
        end else if (bus.We && bus.Wn != 5'd0) begin
            m_mem[bus.Wn] <= bus.D;
        end
    end

    always @(negedge Clk) begin
        if (m_valid) begin
            chk("model_qa", bus.Qa, exp_rd(bus.Rna));
            chk("model_qb", bus.Qb, exp_rd(bus.Rnb));
            chk("model_busy", {31'h0, bus.Busy}, {31'h0, m_sweep});
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.Busy && n < 100) begin
            n++;
            tick();
        end
        if (n >= 100) chk({name, "_timeout"}, 32'h1, 32'h0);
    endtask

    initial begin
        int n;
        Rst = 1'b1;
        bus.We = 1'b0; bus.Wn = '0; bus.D = '0;
        bus.Rna = '0;  bus.Rnb = '0; bus.Clr = 1'b0;
        tick();
        Rst = 1'b0;

        // Reset contents
        chk("reset_busy", {31'h0, bus.Busy}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            bus.Rna = 5'(i);
            bus.Rnb = 5'(31 - i);
            #1;
            chk("reset_qa", bus.Qa, 32'h0);
            chk("reset_qb", bus.Qb, 32'h0);
        end
        tick();

        // Bypass then stored value
        bus.We = 1'b1; bus.Wn = 5'd5; bus.D = 32'hDEADBEEF; bus.Rna = 5'd5; bus.Rnb = 5'd6;
        #2;
        chk("bypass_qa", bus.Qa, 32'hDEADBEEF);
        chk("bypass_qb_other", bus.Qb, 32'h0);
        tick();
        bus.We = 1'b0;
        #2;
        chk("stored_qa", bus.Qa, 32'hDEADBEEF);

        // r0 hardwired to zero
        tick();
        bus.We = 1'b1; bus.Wn = 5'd0; bus.D = 32'h1234; bus.Rna = 5'd0;
        #2;
        chk("r0_bypass", bus.Qa, 32'h0);
        tick();
        bus.We = 1'b0;
        #2;
        chk("r0_after", bus.Qa, 32'h0);

        // Fill and sweep
        for (int i = 1; i < 32; i++) begin
            tick();
            bus.We = 1'b1; bus.Wn = 5'(i); bus.D = i * 32'h01010101;
        end
        tick();
        bus.We = 1'b0; bus.Rna = 5'd31; bus.Rnb = 5'd16;
        #2;
        chk("fill_r31", bus.Qa, 32'h1F1F1F1F);
        chk("fill_r16", bus.Qb, 32'h10101010);
        bus.Clr = 1'b1;
        tick();
        bus.Clr = 1'b0;
        chk("sweep_busy_rise", {31'h0, bus.Busy}, 32'h1);
        n = 0;
        while (bus.Busy && n < 100) begin
            bus.We = 1'b1; bus.Wn = 5'((n % 31) + 1); bus.D = 32'hFFFFFFFF;
            bus.Rna = 5'((n % 31) + 1);
            n++;
            tick();
        end
        bus.We = 1'b0;
        chk("sweep_busy_cycles", 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) begin
            bus.Rna = 5'(i);
            #1;
            chk("sweep_cleared", bus.Qa, 32'h0);
        end

        // Clear wins over a same-cycle write
        tick();
        bus.We = 1'b1; bus.Wn = 5'd7; bus.D = 32'h00000077;
        tick();
        bus.Clr = 1'b1; bus.D = 32'hA5A5A5A5; bus.Rna = 5'd7;
        #2;
        chk("clr_write_dropped_qa", bus.Qa, 32'h00000077);
        tick();
        bus.Clr = 1'b0; bus.We = 1'b0;
        wait_idle("clr_write");
        #2;
        chk("clr_write_r7", bus.Qa, 32'h0);

        // Reset mid-sweep
        tick();
        bus.We = 1'b1; bus.Wn = 5'd20; bus.D = 32'h00002020;
        tick();
        bus.We = 1'b0; bus.Clr = 1'b1;
        tick();
        bus.Clr = 1'b0; bus.Rna = 5'd20;
        repeat (10) tick();
        #2;
        chk("midsweep_r20_old", bus.Qa, 32'h00002020);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        #2;
        chk("rst_abort_busy", {31'h0, bus.Busy}, 32'h0);
        chk("rst_abort_r20", bus.Qa, 32'h0);
        bus.We = 1'b1; bus.Wn = 5'd9; bus.D = 32'h00000099;
        tick();
        bus.We = 1'b0; bus.Rna = 5'd9; bus.Rnb = 5'd9;
        #2;
        chk("post_rst_write_qa", bus.Qa, 32'h00000099);
        chk("post_rst_write_qb", bus.Qb, 32'h00000099);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
